// File: rtl/mem_interface_pkg.sv
`default_nettype none
// ============================================================================
// mem_interface_pkg : FSM state encodings, default timeout, control bundle
// Rev 1.0
// ============================================================================
package mem_interface_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RD_LOAD = 3'd2;
  localparam logic [2:0] S_WR_WAIT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic mdr_read;
    logic mdr_load;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// mem_wait_timer : 4-bit wait counter, flags the increment that reaches TIMEOUT
// Rev 1.0
// ============================================================================
module mem_wait_timer
  import mem_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic clear,
  input  logic cnt_clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (cnt_clr_i) begin
      count_d = '0;
    end else if (cnt_en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted during the last permitted wait cycle so the FSM leaves at that edge.
  assign expired_o = cnt_en_i && (({1'b0, count_q} + 5'd1) == 5'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// mem_interface : Read/Write req/ack memory controller with timeout for the MDR
// Rev 1.0
// ============================================================================
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MAR_out,
  input  logic [DATA_W-1:0] MDR_out,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mdr_read,
  output logic              mdr_load,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              expired;
  logic              waiting;
  ctrl_t             ctrl;

  assign waiting = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock     (clock),
    .clear     (clear),
    .cnt_clr_i (state_q == S_IDLE),
    .cnt_en_i  (waiting && !mem_ack),
    .expired_o (expired)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack is checked before expiry so a last-cycle ack still completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Read && Write)  state_d = S_ERR;
        else if (Read)      state_d = S_RD_WAIT;
        else if (Write)     state_d = S_WR_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_ack)        state_d = S_RD_LOAD;
        else if (expired)   state_d = S_ERR;
      end
      S_RD_LOAD:            state_d = S_DONE;
      S_WR_WAIT: begin
        if (mem_ack)        state_d = S_DONE;
        else if (expired)   state_d = S_ERR;
      end
      S_DONE, S_ERR:        state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl      = '0;
    ctrl.busy = (state_q != S_IDLE);
    case (state_q)
      S_RD_WAIT: ctrl.mem_req = 1'b1;
      S_WR_WAIT: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
      end
      S_RD_LOAD: begin
        ctrl.mdr_read = 1'b1;
        ctrl.mdr_load = 1'b1;
      end
      S_DONE:    ctrl.done = 1'b1;
      S_ERR: begin
        ctrl.done = 1'b1;
        ctrl.err  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && (Read ^ Write)) begin
        addr_q <= MAR_out;
      end
      if ((state_q == S_IDLE) && Write && !Read) begin
        wdata_q <= MDR_out;
      end
      if ((state_q == S_RD_WAIT) && mem_ack) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req   = ctrl.mem_req;
  assign mem_we    = ctrl.mem_we;
  assign mdr_read  = ctrl.mdr_read;
  assign mdr_load  = ctrl.mdr_load;
  assign busy      = ctrl.busy;
  assign done      = ctrl.done;
  assign err       = ctrl.err;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Mdatain   = rdata_q;

endmodule
`default_nettype wire
